// File: rtl/dff_scan_ctrl.sv
// Scan/configuration sequencer around a WIDTH-bit DFF bank: functional capture, parallel CAPTURE,
// serial LOAD (LSB-first) and non-destructive serial READ. READ is built only with DFF_SCAN_READBACK_EN.
module dff_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  input  logic             CMD_VALID,
  input  logic [1:0]       CMD,
  output logic             CMD_READY,
  input  logic             SI,
  output logic             SO,
  output logic             DONE,
  output logic [1:0]       state_dbg
);

  // Handshake: a command is taken on a posedge where CMD_VALID && CMD_READY;
  // CMD_READY is high only in IDLE and commands offered while busy are dropped, not queued.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT_IN  = 2'd1,
    SHIFT_OUT = 2'd2,
    FINISH    = 2'd3
  } state_t;

  localparam logic [1:0] CMD_CAPTURE = 2'b01;
  localparam logic [1:0] CMD_LOAD    = 2'b10;
`ifdef DFF_SCAN_READBACK_EN
  localparam logic [1:0] CMD_READ    = 2'b11;
`endif

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] q_n;
  logic             accept;
  logic             last_shift;

  assign accept     = CMD_VALID && CMD_READY;
  assign last_shift = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      Q     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      Q     <= q_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    q_n     = Q;
    case (state)
      IDLE: begin
        if (accept) begin
          // An accepted command (even NOP) masks the EN capture on this edge.
          case (CMD)
            CMD_CAPTURE: begin
              q_n     = D;
              state_n = FINISH;
            end
            CMD_LOAD: begin
              cnt_n   = '0;
              state_n = SHIFT_IN;
            end
`ifdef DFF_SCAN_READBACK_EN
            CMD_READ: begin
              cnt_n   = '0;
              state_n = SHIFT_OUT;
            end
`endif
            default: ;
          endcase
        end else if (EN) begin
          q_n = D;
        end
      end
      SHIFT_IN: begin
        q_n   = {SI, Q[WIDTH-1:1]};
        cnt_n = cnt + CNT_W'(1);
        if (last_shift) state_n = FINISH;
      end
`ifdef DFF_SCAN_READBACK_EN
      SHIFT_OUT: begin
        // Rotation restores the original contents after WIDTH steps.
        q_n   = {Q[0], Q[WIDTH-1:1]};
        cnt_n = cnt + CNT_W'(1);
        if (last_shift) state_n = FINISH;
      end
`endif
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign CMD_READY = (state == IDLE);
  assign DONE      = (state == FINISH);
  assign state_dbg = state;

`ifdef DFF_SCAN_READBACK_EN
  assign SO = (state == SHIFT_OUT) ? Q[0] : 1'b0;
`else
  assign SO = 1'b0;
`endif

endmodule
